fetch_queue_unit: RTL and testbench

- Parametrised successor to the single-PC fetch stage.
- Owns the PC and issues in-order requests to instruction memory over a valid/ready request channel; it holds at most FQ_DEPTH requests in flight.
- Buffers returned instructions, tagged with their PCs, in a FIFO and presents them to decode through a valid/ready handshake.
- On redirect (branch, jump or hazard resolution) it reloads the PC, flushes the FIFO and discards stale in-flight responses.

---
 rtl/fetch_queue_unit.sv | 140 ++++++++++++++
 tb/tb_fetch_queue_unit.sv | 272 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/fetch_queue_unit.sv
// Instruction fetch queue: owns the PC, issues credit-limited in-order requests to
// instruction memory and buffers PC-tagged responses for decode. Optional macro: FETCH_PERF_EN.
module fetch_queue_unit #(
    parameter int              XLEN     = 32,
    parameter logic [XLEN-1:0] RESET_PC = '0,
    parameter int              FQ_DEPTH = 4
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            redirect,
    input  logic [XLEN-1:0] redirect_pc,
    output logic            imem_req_valid,
    input  logic            imem_req_ready,
    output logic [XLEN-1:0] imem_req_addr,
    input  logic            imem_rsp_valid,
    input  logic [XLEN-1:0] imem_rsp_data,
    output logic            inst_valid,
    input  logic            inst_ready,
    output logic [XLEN-1:0] inst_out,
    output logic [XLEN-1:0] pc_out
`ifdef FETCH_PERF_EN
    ,
    output logic [31:0]     perf_issued,
    output logic [31:0]     perf_dropped,
    output logic [31:0]     perf_starve
`endif
);

    localparam int PW = $clog2(FQ_DEPTH);
    localparam int CW = PW + 1;

    logic [XLEN-1:0] pc;
    logic [CW-1:0]   fifo_count;
    logic [CW-1:0]   outstanding;
    logic [CW-1:0]   drop;
    logic [PW-1:0]   fifo_wr;
    logic [PW-1:0]   fifo_rd;
    logic [PW-1:0]   infl_wr;
    logic [PW-1:0]   infl_rd;

    logic [XLEN-1:0] fifo_inst [FQ_DEPTH];
    logic [XLEN-1:0] fifo_pc   [FQ_DEPTH];
    logic [XLEN-1:0] infl_pc   [FQ_DEPTH];

    logic [CW-1:0]   credits_used;
    logic            req_fire;
    logic            rsp_push;
    logic            rsp_drop;
    logic            pop;
    logic            unused_redirect_lsb;

    assign unused_redirect_lsb = ^redirect_pc[1:0];

    // Credits cover both buffered and in-flight entries, so a response always finds a FIFO slot.
    assign credits_used   = fifo_count + outstanding;
    assign imem_req_valid = !rst && !redirect && (credits_used < CW'(FQ_DEPTH));
    assign imem_req_addr  = pc;
    assign req_fire       = imem_req_valid && imem_req_ready;

    // Responses in a redirect cycle, or owed to a previous redirect, are discarded.
    assign rsp_drop = imem_rsp_valid && (redirect || (drop != '0));
    assign rsp_push = imem_rsp_valid && !redirect && (drop == '0);

    assign inst_valid = (fifo_count != '0);
    assign pop        = inst_valid && inst_ready;

    // NOTE: storage arrays carry no reset; the head outputs are gated by valid instead.
    assign inst_out = inst_valid ? fifo_inst[fifo_rd] : '0;
    assign pc_out   = inst_valid ? fifo_pc[fifo_rd]   : '0;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pc          <= RESET_PC;
            fifo_count  <= '0;
            outstanding <= '0;
            drop        <= '0;
            fifo_wr     <= '0;
            fifo_rd     <= '0;
            infl_wr     <= '0;
            infl_rd     <= '0;
        end else begin
            // NOTE: all state updates use non-blocking assignments so every read sees pre-edge values.
            outstanding <= outstanding + CW'(req_fire) - CW'(imem_rsp_valid);
            if (redirect) begin
                pc         <= {redirect_pc[XLEN-1:2], 2'b00};
                fifo_count <= '0;
                fifo_wr    <= '0;
                fifo_rd    <= '0;
                infl_wr    <= '0;
                infl_rd    <= '0;
                drop       <= outstanding - CW'(imem_rsp_valid);
            end else begin
                if (req_fire) begin
                    pc      <= pc + XLEN'(4);
                    infl_wr <= infl_wr + 1'b1;
                end
                if (rsp_push) begin
                    infl_rd <= infl_rd + 1'b1;
                    fifo_wr <= fifo_wr + 1'b1;
                end
                if (pop) begin
                    fifo_rd <= fifo_rd + 1'b1;
                end
                fifo_count <= fifo_count + CW'(rsp_push) - CW'(pop);
                if (rsp_drop) begin
                    drop <= drop - 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (req_fire) begin
            infl_pc[infl_wr] <= pc;
        end
        if (rsp_push) begin
            fifo_inst[fifo_wr] <= imem_rsp_data;
            fifo_pc[fifo_wr]   <= infl_pc[infl_rd];
        end
    end

`ifdef FETCH_PERF_EN
    function automatic logic [31:0] sat_inc(input logic [31:0] value, input logic en);
        return (en && (value != '1)) ? value + 32'd1 : value;
    endfunction

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            perf_issued  <= '0;
            perf_dropped <= '0;
            perf_starve  <= '0;
        end else begin
            perf_issued  <= sat_inc(perf_issued, req_fire);
            perf_dropped <= sat_inc(perf_dropped, rsp_drop);
            perf_starve  <= sat_inc(perf_starve, inst_ready && !inst_valid);
        end
    end
`endif

endmodule

// File: tb/tb_fetch_queue_unit.sv
// Directed bench for fetch_queue_unit: PC model plus expected-instruction scoreboard,
// with a behavioural instruction memory returning in request order.
module tb_fetch_queue_unit;

    localparam int          XLEN     = 32;
    localparam logic [31:0] RESET_PC = 32'h0000_0100;
    localparam int          FQ_DEPTH = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic        redirect;
    logic [31:0] redirect_pc;
    logic        imem_req_valid;
    logic        imem_req_ready;
    logic [31:0] imem_req_addr;
    logic        imem_rsp_valid;
    logic [31:0] imem_rsp_data;
    logic        inst_valid;
    logic        inst_ready;
    logic [31:0] inst_out;
    logic [31:0] pc_out;
`ifdef FETCH_PERF_EN
    logic [31:0] perf_issued;
    logic [31:0] perf_dropped;
    logic [31:0] perf_starve;
`endif

    fetch_queue_unit #(
        .XLEN     (XLEN),
        .RESET_PC (RESET_PC),
        .FQ_DEPTH (FQ_DEPTH)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .redirect       (redirect),
        .redirect_pc    (redirect_pc),
        .imem_req_valid (imem_req_valid),
        .imem_req_ready (imem_req_ready),
        .imem_req_addr  (imem_req_addr),
        .imem_rsp_valid (imem_rsp_valid),
        .imem_rsp_data  (imem_rsp_data),
        .inst_valid     (inst_valid),
        .inst_ready     (inst_ready),
        .inst_out       (inst_out),
        .pc_out         (pc_out)
`ifdef FETCH_PERF_EN
        ,
        .perf_issued    (perf_issued),
        .perf_dropped   (perf_dropped),
        .perf_starve    (perf_starve)
`endif
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] inst;
    } exp_t;

    exp_t        exp_q[$];
    logic [31:0] mem_q[$];
    logic [31:0] exp_pc;
    int          checks = 0;
    int          errors = 0;
    int          hs_count;
    bit          rsp_en;
    int          first_pop;

    logic        s_hs;
    logic        s_req_valid;
    logic        s_inst_valid;
    logic        s_pop;
    logic [31:0] s_addr;
    logic [31:0] s_pc_out;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return {a[15:0] ^ 16'hBEEF, ~a[15:0]};
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Entered at posedge+1 with this cycle's inputs already set; returns at the next posedge+1.
    task automatic step();
        exp_t e;
        logic [31:0] a;
        @(negedge clk);
        s_req_valid  = imem_req_valid;
        s_addr       = imem_req_addr;
        s_hs         = imem_req_valid && imem_req_ready;
        s_inst_valid = inst_valid;
        s_pop        = inst_valid && inst_ready;
        s_pc_out     = pc_out;
        if (s_pop) begin
            check("sb_nonempty", 32'(exp_q.size() != 0), 32'd1);
            if (exp_q.size() != 0) begin
                e = exp_q.pop_front();
                check("sb_pc_out", pc_out, e.pc);
                check("sb_inst_out", inst_out, e.inst);
            end
        end
        if (s_hs) begin
            hs_count++;
            check("req_addr", imem_req_addr, exp_pc);
            mem_q.push_back(imem_req_addr);
            e.pc   = exp_pc;
            e.inst = mem_word(exp_pc);
            exp_q.push_back(e);
            exp_pc = exp_pc + 32'd4;
        end
        if (redirect) begin
            check("no_issue_on_redirect", 32'(s_hs), 32'd0);
            exp_q.delete();
            exp_pc = {redirect_pc[31:2], 2'b00};
        end
        @(posedge clk);
        #1;
        if (rsp_en && mem_q.size() != 0) begin
            a              = mem_q.pop_front();
            imem_rsp_valid = 1'b1;
            imem_rsp_data  = mem_word(a);
        end else begin
            imem_rsp_valid = 1'b0;
            imem_rsp_data  = '0;
        end
    endtask

    task automatic do_reset();
        rst            = 1'b1;
        redirect       = 1'b0;
        redirect_pc    = '0;
        imem_req_ready = 1'b0;
        inst_ready     = 1'b0;
        imem_rsp_valid = 1'b0;
        imem_rsp_data  = '0;
        rsp_en         = 1'b0;
        hs_count       = 0;
        exp_pc         = RESET_PC;
        mem_q.delete();
        exp_q.delete();
        #2;
        check("rst_req_valid", 32'(imem_req_valid), 32'd0);
        check("rst_inst_valid", 32'(inst_valid), 32'd0);
        check("rst_inst_out", inst_out, 32'd0);
        check("rst_pc_out", pc_out, 32'd0);
        @(posedge clk);
        @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    task automatic wait_first_pop(input string tag, input logic [31:0] want_pc);
        first_pop = 0;
        for (int i = 1; i <= 20 && first_pop == 0; i++) begin
            step();
            if (s_pop) first_pop = i;
        end
        check({tag, "_pop_seen"}, 32'(first_pop != 0), 32'd1);
        if (first_pop != 0) check({tag, "_first_pc"}, s_pc_out, want_pc);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        // Streaming with 1-cycle memory and an always-ready decoder.
        do_reset();
        imem_req_ready = 1'b1;
        inst_ready     = 1'b1;
        rsp_en         = 1'b1;
        step();
        check("t1_first_req_valid", 32'(s_req_valid), 32'd1);
        check("t1_first_addr", s_addr, RESET_PC);
        first_pop = 0;
        for (int i = 2; i <= 10; i++) begin
            step();
            if (first_pop != 0) begin
                check("t1_stream_valid", 32'(s_inst_valid), 32'd1);
            end else if (s_pop) begin
                first_pop = i;
                check("t1_first_pc", s_pc_out, RESET_PC);
            end
        end
        check("t1_first_pop_cycle", 32'(first_pop), 32'd3);

        // Decode stall: credits cap issue at FQ_DEPTH.
        do_reset();
        imem_req_ready = 1'b1;
        rsp_en         = 1'b1;
        for (int i = 0; i < 10; i++) step();
        check("t2_issued", 32'(hs_count), 32'(FQ_DEPTH));
        check("t2_req_valid_low", 32'(s_req_valid), 32'd0);
        check("t2_fifo_held", 32'(exp_q.size()), 32'(FQ_DEPTH));
        check("t2_head_pc", pc_out, RESET_PC);
        inst_ready = 1'b1;
        for (int i = 0; i < FQ_DEPTH; i++) begin
            step();
            check("t2_drain_pop", 32'(s_pop), 32'd1);
        end

        // Memory back-pressure: address holds, PC does not advance.
        do_reset();
        inst_ready = 1'b1;
        rsp_en     = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            check("t3_valid_held", 32'(s_req_valid), 32'd1);
            check("t3_addr_held", s_addr, RESET_PC);
        end
        imem_req_ready = 1'b1;
        step();
        check("t3_accept_addr", s_addr, RESET_PC);
        check("t3_accept_hs", 32'(s_hs), 32'd1);
        step();
        check("t3_next_addr", s_addr, RESET_PC + 32'd4);

        // Redirect with three requests in flight.
        do_reset();
        imem_req_ready = 1'b1;
        inst_ready     = 1'b1;
        for (int i = 0; i < 3; i++) step();
        check("t4_outstanding", 32'(hs_count), 32'd3);
        redirect    = 1'b1;
        redirect_pc = 32'h0000_2003;
        step();
        check("t4_redirect_no_req", 32'(s_req_valid), 32'd0);
        redirect = 1'b0;
        rsp_en   = 1'b1;
        step();
        check("t4_new_req_valid", 32'(s_req_valid), 32'd1);
        check("t4_new_addr", s_addr, 32'h0000_2000);
        wait_first_pop("t4", 32'h0000_2000);
`ifdef FETCH_PERF_EN
        check("t4_perf_dropped", perf_dropped, 32'd3);
        check("t4_perf_issued", perf_issued, 32'(hs_count));
`endif

        // Redirect coinciding with a response, then a second redirect next cycle.
        do_reset();
        imem_req_ready = 1'b1;
        inst_ready     = 1'b1;
        rsp_en         = 1'b1;
        for (int i = 0; i < 5; i++) step();
        check("t5_rsp_in_redirect", 32'(imem_rsp_valid), 32'd1);
        redirect    = 1'b1;
        redirect_pc = 32'h0000_5000;
        step();
        redirect_pc = 32'h0000_3000;
        step();
        check("t5_empty_after_redirect", 32'(s_inst_valid), 32'd0);
        redirect = 1'b0;
        step();
        check("t5_new_addr", s_addr, 32'h0000_3000);
        wait_first_pop("t5", 32'h0000_3000);

        // Mid-stream reset clears everything asynchronously.
        do_reset();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
